upstream_link_sched: RTL

UPSTREAM_LINK_SCHED -- requirements
Module: upstream_link_sched

---
 rtl/upstream_link_sched.sv | 120 ++++++++++++
 1 files changed

// File: rtl/upstream_link_sched.sv
// Two-requester round-robin scheduler that serialises 64-bit words into 4 link beats under token credits.
// Optional per-requester grant counters are enabled with UPSTREAM_LINK_SCHED_STATS_EN.
module upstream_link_sched #(
  parameter int CREDITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [63:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [63:0] req1_data,
  output logic        req1_ready,
  input  logic        io_token,
  output logic        io_valid_out,
  output logic [7:0]  io_data_out_ch0,
  output logic [7:0]  io_data_out_ch1,
  output logic [6:0]  sent_cnt,
  output logic [6:0]  finish_cnt,
  output logic        token_err
`ifdef UPSTREAM_LINK_SCHED_STATS_EN
  ,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1
`endif
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state;
  logic [1:0]  beat;
  logic [63:0] word;
  logic        prio1;
  logic [6:0]  outstanding;
  logic        credit_ok;
  logic        slot_free;
  logic        accept;
  logic [63:0] acc_data;
  logic [1:0]  next_beat;
  logic [63:0] next_word;

  assign outstanding = sent_cnt - finish_cnt;
  assign credit_ok   = {1'b0, outstanding} < 8'(CREDITS);
  assign slot_free   = (state == IDLE) || (beat == 2'd3);
  assign accept      = req0_ready | req1_ready;
  assign acc_data    = req0_ready ? req0_data : req1_data;
  assign next_beat   = beat + 2'd1;
  assign next_word   = word >> {next_beat, 4'b0000};

  // prio1 set means req1 wins a tie; a lone valid always wins.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst && credit_ok && slot_free) begin
      if (req0_valid && (!req1_valid || !prio1)) begin
        req0_ready = 1'b1;
      end else if (req1_valid) begin
        req1_ready = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      beat            <= 2'd0;
      word            <= 64'd0;
      prio1           <= 1'b0;
      sent_cnt        <= 7'd0;
      finish_cnt      <= 7'd0;
      token_err       <= 1'b0;
      io_valid_out    <= 1'b0;
      io_data_out_ch0 <= 8'd0;
      io_data_out_ch1 <= 8'd0;
    end else begin
      if (accept) begin
        state           <= SEND;
        beat            <= 2'd0;
        word            <= acc_data;
        io_valid_out    <= 1'b1;
        io_data_out_ch0 <= acc_data[7:0];
        io_data_out_ch1 <= acc_data[15:8];
        sent_cnt        <= sent_cnt + 7'd1;
        prio1           <= req0_ready;
      end else if (state == SEND && beat != 2'd3) begin
        beat            <= next_beat;
        io_data_out_ch0 <= next_word[7:0];
        io_data_out_ch1 <= next_word[15:8];
      end else begin
        state           <= IDLE;
        beat            <= 2'd0;
        io_valid_out    <= 1'b0;
        io_data_out_ch0 <= 8'd0;
        io_data_out_ch1 <= 8'd0;
      end

      // Tokens that would drive the outstanding count negative are dropped.
      if (io_token) begin
        if (outstanding >= 7'd8) begin
          finish_cnt <= finish_cnt + 7'd8;
        end else begin
          token_err <= 1'b1;
        end
      end
    end
  end

`ifdef UPSTREAM_LINK_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= 16'd0;
      grant_cnt1 <= 16'd0;
    end else begin
      if (req0_ready && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req1_ready && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule
